shadow_ctx_spill: RTL and testbench

Spill engine directly downstream of the integer register file's shadow bank. After the register file has captured the 16 caller-saved registers into its shadow bank and bumped `sp`, this block walks the shadow bank through its read port. It issues one valid/ready store request per entry, laying the context frame out in memory at the new stack pointer. It reports completion, or abort on flush, to the interrupt controller.

---
 rtl/config_pkg.sv | 10 +
 rtl/shadow_ctx_spill.sv | 101 ++++++++++
 tb/tb_shadow_ctx_spill.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/config_pkg.sv
// Minimal core-configuration package: only the datapath width is consumed here.
package config_pkg;

    typedef struct packed {
        int unsigned XLEN;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{XLEN: 64};

endpackage

// File: rtl/shadow_ctx_spill.sv
// Walks the register-file shadow bank and stores each entry as one context-frame
// word at the already-decremented stack pointer; reports done/abort/overrun pulses.
module shadow_ctx_spill #(
    parameter config_pkg::cva6_cfg_t CVA6Cfg          = config_pkg::cva6_cfg_empty,
    parameter int unsigned           NUM_WORDS_SHADOW = 16,
    parameter int unsigned           IDX_WIDTH        = $clog2(NUM_WORDS_SHADOW)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      spill_req_i,
    input  logic                      flush_i,
    input  logic [CVA6Cfg.XLEN-1:0]   sp_i,
    output logic [IDX_WIDTH-1:0]      shadow_raddr_o,
    input  logic [CVA6Cfg.XLEN-1:0]   shadow_rdata_i,
    output logic                      st_req_o,
    input  logic                      st_gnt_i,
    output logic [CVA6Cfg.XLEN-1:0]   st_addr_o,
    output logic [CVA6Cfg.XLEN-1:0]   st_data_o,
    output logic [CVA6Cfg.XLEN/8-1:0] st_be_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      aborted_o,
    output logic                      overrun_o
);

    localparam int unsigned XLEN = CVA6Cfg.XLEN;

    typedef enum logic [1:0] {S_IDLE, S_SPILL, S_DRAIN} state_e;

    state_e               r_state, w_state_nxt;
    logic [IDX_WIDTH-1:0] r_idx;
    logic [XLEN-1:0]      r_base;
    logic                 r_abort, r_done, r_aborted, r_overrun;

    logic                 w_req, w_gnt, w_last, w_start;
    logic [XLEN-1:0]      w_off;

    assign w_req   = (r_state == S_SPILL);
    assign w_gnt   = w_req && st_gnt_i;
    assign w_last  = (r_idx == IDX_WIDTH'(NUM_WORDS_SHADOW - 1));
    assign w_start = (r_state == S_IDLE) && spill_req_i;
    assign w_off   = XLEN'(r_idx) << $clog2(XLEN / 8);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // A flush only redirects the FSM once the in-flight request is granted;
    // the final grant always completes the frame.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (spill_req_i) w_state_nxt = S_SPILL;
            S_SPILL: begin
                if (w_gnt) begin
                    if (w_last)                    w_state_nxt = S_IDLE;
                    else if (r_abort || flush_i)   w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_idx     <= '0;
            r_base    <= '0;
            r_abort   <= 1'b0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_done    <= w_gnt && w_last;
            r_aborted <= (r_state == S_DRAIN);
            r_overrun <= spill_req_i && (r_state != S_IDLE);
            if (w_start) begin
                r_base  <= sp_i;
                r_idx   <= '0;
                r_abort <= 1'b0;
            end
            if (w_req) begin
                if (flush_i) r_abort <= 1'b1;
                // Index parks at 0 whenever the walk ends so the read port idles at 0.
                if (w_gnt) r_idx <= (w_last || r_abort || flush_i) ? '0 : r_idx + 1'b1;
            end
        end
    end

    assign shadow_raddr_o = r_idx;
    assign st_req_o       = w_req;
    assign st_addr_o      = w_req ? r_base + w_off : '0;
    assign st_data_o      = w_req ? shadow_rdata_i : '0;
    assign st_be_o        = {(XLEN / 8){w_req}};
    assign busy_o         = (r_state != S_IDLE);
    assign done_o         = r_done;
    assign aborted_o      = r_aborted;
    assign overrun_o      = r_overrun;

endmodule

// File: tb/tb_shadow_ctx_spill.sv
// Scenario bench for shadow_ctx_spill: per-feature tasks plus a store scoreboard.
module tb_shadow_ctx_spill;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spill_req = 1'b0;
    logic        flush = 1'b0;
    logic        gnt = 1'b0;
    logic [63:0] sp = '0;
    logic [3:0]  raddr;
    logic [63:0] rdata;
    logic        st_req;
    logic [63:0] st_addr, st_data;
    logic [7:0]  st_be;
    logic        busy, done, aborted, overrun;

    logic [63:0] shadow [N];

    typedef struct packed {
        logic [63:0] addr;
        logic [63:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    assign rdata = shadow[raddr];

    shadow_ctx_spill dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .spill_req_i    (spill_req),
        .flush_i        (flush),
        .sp_i           (sp),
        .shadow_raddr_o (raddr),
        .shadow_rdata_i (rdata),
        .st_req_o       (st_req),
        .st_gnt_i       (gnt),
        .st_addr_o      (st_addr),
        .st_data_o      (st_data),
        .st_be_o        (st_be),
        .busy_o         (busy),
        .done_o         (done),
        .aborted_o      (aborted),
        .overrun_o      (overrun)
    );

    // Scoreboard: every granted store must match the next expected frame word.
    always @(negedge clk) begin
        if (rst_n && st_req && gnt) begin
            exp_t e;
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: store addr=%h data=%h, want no store", st_addr, st_data);
            end else begin
                e = sb.pop_front();
                if (st_addr !== e.addr || st_data !== e.data || st_be !== 8'hFF) begin
                    n_fail++;
                    $display("FAIL sb_store: addr=%h data=%h be=%h, want addr=%h data=%h be=ff",
                             st_addr, st_data, st_be, e.addr, e.data);
                end
            end
        end
    end

    task automatic push_frame(input logic [63:0] base, input int n);
        for (int i = 0; i < n; i++) sb.push_back('{addr: base + 64'(8 * i), data: shadow[i]});
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic start_spill(input logic [63:0] base);
        sp = base;
        next_cycle();
        spill_req = 1'b1;
    endtask

    task automatic test_sb_empty(input string name);
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_sb_left: %0d stores missing, want 0", name, sb.size());
        end
        sb.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) next_cycle();
        @(negedge clk);
        n_chk++;
        if ({st_req, busy, done, aborted, overrun} !== 5'b0 || raddr !== 4'd0 ||
            st_addr !== 64'd0 || st_data !== 64'd0 || st_be !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_state: req=%b busy=%b done=%b ab=%b ov=%b raddr=%0d addr=%h data=%h be=%h, want all 0",
                     st_req, busy, done, aborted, overrun, raddr, st_addr, st_data, st_be);
        end
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_continuous();
        push_frame(64'h8000_0FC0, N);
        gnt = 1'b1;
        start_spill(64'h8000_0FC0);
        for (int k = 1; k <= 18; k++) begin
            next_cycle();
            spill_req = 1'b0;
            @(negedge clk);
            n_chk++;
            if (done !== (k == 17) || busy !== (k <= 16) || st_req !== (k <= 16) ||
                (k <= 16 && (raddr !== 4'(k - 1) || st_be !== 8'hFF))) begin
                n_fail++;
                $display("FAIL cont_c%0d: done=%b busy=%b req=%b raddr=%0d be=%h, want done=%b busy=%b req=%b raddr=%0d",
                         k, done, busy, st_req, raddr, st_be, k == 17, k <= 16, k <= 16, k - 1);
            end
        end
        gnt = 1'b0;
        test_sb_empty("cont");
    endtask

    task automatic test_stall();
        push_frame(64'h8000_0FC0, N);
        start_spill(64'h8000_0FC0);
        for (int k = 1; k <= 21; k++) begin
            next_cycle();
            spill_req = 1'b0;
            gnt = !(k >= 6 && k <= 8);
            @(negedge clk);
            n_chk++;
            if (done !== (k == 20)) begin
                n_fail++;
                $display("FAIL stall_done_c%0d: done=%b, want %b", k, done, k == 20);
            end
            if (k >= 6 && k <= 9) begin
                n_chk++;
                if (st_req !== 1'b1 || st_addr !== 64'h8000_0FE8 || st_data !== 64'h1005) begin
                    n_fail++;
                    $display("FAIL stall_hold_c%0d: req=%b addr=%h data=%h, want 1 80000fe8 1005",
                             k, st_req, st_addr, st_data);
                end
            end
        end
        gnt = 1'b0;
        test_sb_empty("stall");
    endtask

    task automatic test_flush();
        push_frame(64'h8000_0FC0, 8);
        gnt = 1'b1;
        start_spill(64'h8000_0FC0);
        for (int k = 1; k <= 15; k++) begin
            next_cycle();
            spill_req = 1'b0;
            gnt = !(k == 8 || k == 9);
            flush = (k == 8);
            @(negedge clk);
            n_chk++;
            if (done !== 1'b0 || aborted !== (k == 12) || busy !== (k <= 11) ||
                (k >= 11 && st_req !== 1'b0) ||
                ((k == 8 || k == 9) && (st_req !== 1'b1 || raddr !== 4'd7))) begin
                n_fail++;
                $display("FAIL flush_c%0d: done=%b ab=%b busy=%b req=%b raddr=%0d, want done=0 ab=%b busy=%b",
                         k, done, aborted, busy, st_req, raddr, k == 12, k <= 11);
            end
        end
        flush = 1'b0;
        gnt = 1'b0;
        test_sb_empty("flush");
    endtask

    task automatic test_wrap();
        push_frame(64'hFFFF_FFFF_FFFF_FFC0, N);
        gnt = 1'b1;
        start_spill(64'hFFFF_FFFF_FFFF_FFC0);
        for (int k = 1; k <= 18; k++) begin
            next_cycle();
            spill_req = 1'b0;
            flush = (k == 16);
            @(negedge clk);
            n_chk++;
            if (done !== (k == 17) || aborted !== 1'b0) begin
                n_fail++;
                $display("FAIL wrap_pulse_c%0d: done=%b ab=%b, want done=%b ab=0", k, done, aborted, k == 17);
            end
            if (k == 9 || k == 16) begin
                n_chk++;
                if (st_addr !== ((k == 9) ? 64'h0 : 64'h38)) begin
                    n_fail++;
                    $display("FAIL wrap_addr_c%0d: addr=%h, want %h", k, st_addr, (k == 9) ? 64'h0 : 64'h38);
                end
            end
        end
        flush = 1'b0;
        gnt = 1'b0;
        test_sb_empty("wrap");
    endtask

    task automatic test_overrun();
        push_frame(64'h8000_0FC0, N);
        gnt = 1'b1;
        start_spill(64'h8000_0FC0);
        for (int k = 1; k <= 18; k++) begin
            next_cycle();
            spill_req = (k == 5);
            sp = (k == 5) ? 64'hDEAD_0000 : 64'h8000_0FC0;
            @(negedge clk);
            n_chk++;
            if (overrun !== (k == 6) || done !== (k == 17)) begin
                n_fail++;
                $display("FAIL overrun_c%0d: ov=%b done=%b, want ov=%b done=%b", k, overrun, done, k == 6, k == 17);
            end
        end
        gnt = 1'b0;
        test_sb_empty("overrun");
    endtask

    task automatic test_back_to_back();
        push_frame(64'h4000, N);
        gnt = 1'b1;
        start_spill(64'h4000);
        for (int k = 1; k <= 35; k++) begin
            next_cycle();
            spill_req = (k == 17);
            if (k == 17) begin
                sp = 64'h5000;
                push_frame(64'h5000, N);
            end
            @(negedge clk);
            n_chk++;
            if (done !== (k == 17 || k == 34) || overrun !== 1'b0 ||
                (k == 18 && (st_req !== 1'b1 || st_addr !== 64'h5000))) begin
                n_fail++;
                $display("FAIL b2b_c%0d: done=%b ov=%b req=%b addr=%h, want done=%b ov=0",
                         k, done, overrun, st_req, st_addr, k == 17 || k == 34);
            end
        end
        gnt = 1'b0;
        test_sb_empty("b2b");
    endtask

    task automatic test_reset_mid();
        push_frame(64'h8000_0FC0, N);
        gnt = 1'b1;
        start_spill(64'h8000_0FC0);
        for (int k = 1; k <= 9; k++) begin
            next_cycle();
            spill_req = 1'b0;
        end
        n_chk++;
        if (st_req !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pre: req=%b, want 1", st_req);
        end
        #1 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({st_req, busy, done, aborted, overrun} !== 5'b0 || raddr !== 4'd0 ||
            st_addr !== 64'd0 || st_data !== 64'd0 || st_be !== 8'd0) begin
            n_fail++;
            $display("FAIL rstmid_async: req=%b busy=%b raddr=%0d addr=%h data=%h be=%h, want all 0",
                     st_req, busy, raddr, st_addr, st_data, st_be);
        end
        sb.delete();
        next_cycle();
        rst_n = 1'b1;
        push_frame(64'h2000, N);
        sp = 64'h2000;
        spill_req = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            next_cycle();
            spill_req = 1'b0;
            @(negedge clk);
            n_chk++;
            if (done !== (k == 17) ||
                (k == 1 && (st_req !== 1'b1 || raddr !== 4'd0 || st_addr !== 64'h2000 || st_data !== 64'h1000))) begin
                n_fail++;
                $display("FAIL rstmid_new_c%0d: done=%b req=%b raddr=%0d addr=%h data=%h, want done=%b",
                         k, done, st_req, raddr, st_addr, st_data, k == 17);
            end
        end
        gnt = 1'b0;
        test_sb_empty("rstmid");
    endtask

    initial begin
        for (int i = 0; i < N; i++) shadow[i] = 64'h1000 + 64'(i);
        test_reset();
        test_continuous();
        test_stall();
        test_flush();
        test_wrap();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        repeat (2) next_cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
